// File: rtl/wb_manager.sv
// rtl/wb_manager.sv - single-transfer Wishbone manager bridging a held CPU-side read/write request.
// Optional WB_TIMEOUT_EN aborts a REQ that sees no ack_i within TIMEOUT cycles and flags err_o.
module wb_manager #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic        busy_o,
  output logic [31:0] cpu_dat_o,
  output logic        err_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, RELEASE} state_t;
  state_t state;

`ifdef WB_TIMEOUT_EN
  // Sized so cnt + 1 can reach TIMEOUT without wrapping.
  localparam int CW = ($clog2(TIMEOUT + 2) > 8) ? $clog2(TIMEOUT + 2) : 8;
  logic [CW-1:0] cnt;
  logic          expired;
  assign expired = ((cnt + CW'(1)) >= CW'(TIMEOUT));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign err_o = 1'b0;
`endif

  always_comb begin
    busy_o = 1'b0;
    case (state)
      IDLE:    busy_o = read_i | write_i;
      REQ:     busy_o = 1'b1;
      RESP:    busy_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      sel_o     <= 4'h0;
      adr_o     <= 32'h0;
      dat_o     <= 32'h0;
      cpu_dat_o <= 32'h0;
`ifdef WB_TIMEOUT_EN
      err_o     <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (read_i || write_i) begin
            adr_o <= adr_i;
            sel_o <= sel_i;
            dat_o <= cpu_dat_i;
            we_o  <= write_i;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            state <= REQ;
`ifdef WB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        REQ: begin
          // An ack in the same cycle as expiry still completes normally.
          if (ack_i) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            cpu_dat_o <= we_o ? 32'h0 : dat_i;
            state     <= RESP;
`ifdef WB_TIMEOUT_EN
          end else if (expired) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            cpu_dat_o <= 32'h0;
            err_o     <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
`endif
          end
        end
        RESP: begin
`ifdef WB_TIMEOUT_EN
          err_o <= 1'b0;
`endif
          state <= RELEASE;
        end
        default: begin
          if (!read_i && !write_i)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_manager.sv
// tb/tb_wb_manager.sv - directed self-checking bench for wb_manager (default and WB_TIMEOUT_EN builds).
module tb_wb_manager;

  logic        clk = 1'b0;
  logic        nRST;
  logic        read_i, write_i, ack_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i, cpu_dat_i, dat_i;
  logic        busy_o, err_o, we_o, cyc_o, stb_o;
  logic [31:0] cpu_dat_o, adr_o, dat_o;
  logic [3:0]  sel_o;

  int nvec = 0;
  int nerr = 0;
  int hi_cnt;

  wb_manager #(.TIMEOUT(4)) dut (
    .clk(clk), .nRST(nRST), .read_i(read_i), .write_i(write_i), .sel_i(sel_i),
    .adr_i(adr_i), .cpu_dat_i(cpu_dat_i), .busy_o(busy_o), .cpu_dat_o(cpu_dat_o),
    .err_o(err_o), .dat_i(dat_i), .ack_i(ack_i), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    nRST = 1'b0; read_i = 0; write_i = 0; ack_i = 0;
    sel_i = 0; adr_i = 0; cpu_dat_i = 0; dat_i = 0;
    nxt(); #1;
    chk("rst_cyc", {31'b0, cyc_o}, 0);
    chk("rst_stb", {31'b0, stb_o}, 0);
    chk("rst_we", {31'b0, we_o}, 0);
    chk("rst_err", {31'b0, err_o}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_cpu_dat", cpu_dat_o, 0);
    chk("rst_adr", adr_o, 0);
    nxt(); nRST = 1'b1;

    // Zero-wait read
    nxt(); read_i = 1; adr_i = 32'h40; sel_i = 4'hF; #1;
    chk("rd_c0_busy", {31'b0, busy_o}, 1);
    chk("rd_c0_stb", {31'b0, stb_o}, 0);
    nxt(); ack_i = 1; dat_i = 32'h1234_5678; #1;
    chk("rd_c1_stb", {31'b0, stb_o}, 1);
    chk("rd_c1_cyc", {31'b0, cyc_o}, 1);
    chk("rd_c1_we", {31'b0, we_o}, 0);
    chk("rd_c1_adr", adr_o, 32'h40);
    chk("rd_c1_sel", {28'b0, sel_o}, 4'hF);
    nxt(); ack_i = 0; dat_i = 32'hFFFF_FFFF; #1;
    chk("rd_c2_busy", {31'b0, busy_o}, 1);
    chk("rd_c2_data", cpu_dat_o, 32'h1234_5678);
    chk("rd_c2_stb", {31'b0, stb_o}, 0);
    nxt(); #1;
    chk("rd_c3_busy", {31'b0, busy_o}, 0);
    // Request held in RELEASE must not re-issue
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      if (cyc_o || busy_o) hi_cnt++;
    end
    chk("rel_no_reissue", hi_cnt, 0);
    nxt(); read_i = 0; #1;
    nxt(); ack_i = 1; #1;
    chk("idle_ack_busy", {31'b0, busy_o}, 0);
    nxt(); ack_i = 0; #1;
    chk("idle_ack_cyc", {31'b0, cyc_o}, 0);
    chk("hold_cpu_dat", cpu_dat_o, 32'h1234_5678);

    // Write with 3 wait states
    nxt(); write_i = 1; adr_i = 32'h100; cpu_dat_i = 32'hDEAD_BEEF; sel_i = 4'h3; #1;
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      nxt(); cpu_dat_i = 32'h0; adr_i = 32'h0; sel_i = 4'h0;
      ack_i = (i == 3); #1;
      if (dat_o == 32'hDEAD_BEEF && sel_o == 4'h3 && we_o && stb_o && adr_o == 32'h100) hi_cnt++;
    end
    chk("wr_stable_cycles", hi_cnt, 4);
    nxt(); ack_i = 0; #1;
    chk("wr_resp_busy", {31'b0, busy_o}, 1);
    chk("wr_resp_data", cpu_dat_o, 0);
    chk("wr_resp_we", {31'b0, we_o}, 0);
    nxt(); write_i = 0; #1;

    // Simultaneous read and write: write wins
    nxt(); read_i = 1; write_i = 1; adr_i = 32'h8; #1;
    nxt(); ack_i = 1; dat_i = 32'h5555_AAAA; #1;
    chk("prio_we", {31'b0, we_o}, 1);
    nxt(); ack_i = 0; #1;
    chk("prio_data", cpu_dat_o, 0);
    nxt(); read_i = 0; write_i = 0; #1;

    // Async reset mid-REQ, then restart with read held
    nxt(); read_i = 1; adr_i = 32'h80; sel_i = 4'h1; #1;
    nxt(); #1;
    chk("pre_rst_stb", {31'b0, stb_o}, 1);
    #1 nRST = 1'b0; #1;
    chk("midrst_cyc", {31'b0, cyc_o}, 0);
    chk("midrst_stb", {31'b0, stb_o}, 0);
    chk("midrst_adr", adr_o, 0);
    chk("midrst_cpu_dat", cpu_dat_o, 0);
    nxt(); nRST = 1'b1; #1;
    chk("post_rst_busy", {31'b0, busy_o}, 1);
    nxt(); ack_i = 1; dat_i = 32'hCAFE_F00D; #1;
    chk("post_rst_adr", adr_o, 32'h80);
    nxt(); ack_i = 0; #1;
    chk("post_rst_data", cpu_dat_o, 32'hCAFE_F00D);
    nxt(); read_i = 0; #1;

    // Unacknowledged read
    nxt(); read_i = 1; adr_i = 32'hC0; #1;
`ifdef WB_TIMEOUT_EN
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      if (stb_o) hi_cnt++;
    end
    chk("to_stb_cycles", hi_cnt, 4);
    nxt(); #1;
    chk("to_stb_low", {31'b0, stb_o}, 0);
    chk("to_err", {31'b0, err_o}, 1);
    chk("to_data", cpu_dat_o, 0);
    chk("to_busy", {31'b0, busy_o}, 1);
    nxt(); #1;
    chk("to_err_clr", {31'b0, err_o}, 0);
    chk("to_release", {31'b0, busy_o}, 0);
`else
    hi_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      nxt(); #1;
      if (stb_o && !err_o) hi_cnt++;
    end
    chk("nto_stb_cycles", hi_cnt, 100);
    ack_i = 1; dat_i = 32'h0BAD_0BAD;
    nxt(); ack_i = 0; #1;
    chk("nto_data", cpu_dat_o, 32'h0BAD_0BAD);
    chk("nto_err", {31'b0, err_o}, 0);
`endif
    nxt(); read_i = 0;
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wb_manager.md
WB_MANAGER -- requirements
Module: wb_manager

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum number of REQ cycles to wait for ack_i (used only with WB_TIMEOUT_EN).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: nRST  input  1  reset; asynchronous and active-low.
REQ-004 Port: read_i  input  1  CPU-side read request, held until busy_o falls.
REQ-005 Port: write_i  input  1  CPU-side write request, held until busy_o falls.
REQ-006 Port: sel_i  input  4  CPU-side byte lane select.
REQ-007 Port: adr_i  input  32  CPU-side byte address.
REQ-008 Port: cpu_dat_i  input  32  CPU-side write data.
REQ-009 Port: busy_o  output  1  transaction in progress; read data valid while high in RESP.
REQ-010 Port: cpu_dat_o  output  32  read data returned to CPU side.
REQ-011 Port: err_o  output  1  transaction terminated by timeout.
REQ-012 Port: dat_i  input  32  Wishbone read data from slave.
REQ-013 Port: ack_i  input  1  Wishbone slave acknowledge.
REQ-014 Port: adr_o, dat_o  output  32 each  Wishbone address and write data.
REQ-015 Port: sel_o  output  4  Wishbone byte select.
REQ-016 Port: we_o, cyc_o, stb_o  output  1 each  Wishbone write enable, cycle, strobe.

Function
REQ-017 State machine SHALL have states IDLE, REQ, RESP, RELEASE.
REQ-018 IDLE: on (read_i | write_i), SHALL register adr_i, sel_i and cpu_dat_i into adr_o/sel_o/dat_o, set cyc_o=stb_o=1, set we_o=write_i, and enter REQ next cycle.
REQ-019 If read_i and write_i are both high in IDLE, write SHALL take priority (we_o=1).
REQ-020 busy_o SHALL be combinational: in IDLE = read_i|write_i; 1 in REQ and RESP; 0 in RELEASE.
REQ-021 REQ: adr_o/sel_o/dat_o/we_o SHALL stay stable until ack_i; on ack_i, cyc_o/stb_o/we_o SHALL clear next edge and state SHALL enter RESP.
REQ-022 On read ack, cpu_dat_o SHALL capture dat_i; on write ack, cpu_dat_o SHALL be 0.
REQ-023 RESP SHALL last exactly one cycle with busy_o=1 and cpu_dat_o valid, then enter RELEASE.
REQ-024 RELEASE SHALL hold busy_o=0 and remain until read_i=0 and write_i=0, then enter IDLE; a held request is never re-issued.
REQ-025 Latency for a zero-wait slave: request seen cycle 0, stb_o high cycle 1, ack cycle 1, RESP cycle 2, busy_o low cycle 3.
REQ-026 cpu_dat_o SHALL hold its value through RELEASE and IDLE until the next ack.
REQ-027 ack_i outside REQ SHALL be ignored.

Reset
REQ-028 On nRST low, SHALL immediately set state=IDLE and cyc_o, stb_o, we_o, err_o, sel_o, adr_o, dat_o, cpu_dat_o to 0, including mid-transaction.
REQ-029 After reset release with read_i high, a new transaction SHALL start from IDLE per REQ-018.

Configuration
REQ-030 Macro WB_TIMEOUT_EN: when defined, an 8+-bit counter SHALL clear on REQ entry and increment each REQ cycle without ack_i; on reaching TIMEOUT, cyc_o/stb_o SHALL clear, cpu_dat_o=0, err_o=1 in RESP only, then normal RELEASE.
REQ-031 Without WB_TIMEOUT_EN, REQ SHALL wait indefinitely for ack_i and err_o SHALL be constant 0.

Verification
REQ-032 Read, adr_i=0x0000_0040, sel_i=0xF, slave acks cycle 1 with dat_i=0x1234_5678 -> cyc_o/stb_o high 1 cycle, we_o=0, busy_o high cycles 0-2, cpu_dat_o=0x1234_5678 in cycle 2.
REQ-033 Write, adr_i=0x0000_0100, cpu_dat_i=0xDEAD_BEEF, sel_i=0x3, ack after 3 wait cycles -> dat_o=0xDEAD_BEEF, sel_o=0x3, we_o=1 stable 4 cycles; cpu_dat_o=0.
REQ-034 read_i held 5 cycles after busy_o falls -> remains in RELEASE, exactly one Wishbone cycle issued.
REQ-035 nRST pulsed low during REQ -> cyc_o/stb_o low same cycle, state IDLE, cpu_dat_o=0.
REQ-036 WB_TIMEOUT_EN, TIMEOUT=4, no ack -> stb_o drops after 4 REQ cycles, err_o=1 for one cycle, cpu_dat_o=0; without macro, stb_o stays high 100 cycles.
